dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of REQ-state cycles without bus_ack_i before the transaction is aborted (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous and active-high (port name kept per codebase convention, polarity fixed active-high).
REQ-004 core_ce_i  input  1  SHALL carry the core data-port access request (core data_ce_o).
REQ-005 core_we_i  input  1  SHALL select write (1) or read (0) (core data_we_o).
REQ-006 core_addr_i  input  32  SHALL carry the byte address (core data_addr_o).
REQ-007 core_wdata_i  input  32  SHALL carry the store data (core data_o).
REQ-008 core_rdata_o  output  32  SHALL return load data to the core (core data_i).
REQ-009 mem_stall_req_o  output  1  SHALL drive the core stall unit's memory stall request.
REQ-010 bus_req_o, bus_we_o  output  1 each  SHALL form the external memory request and write select.
REQ-011 bus_addr_o, bus_wdata_o  output  32 each  SHALL carry the word-aligned address and store data.
REQ-012 bus_ack_i  input  1, bus_rdata_i  input  32  SHALL carry completion and read data from the external memory.
REQ-013 err_o  output  1  SHALL flag a timeout or misaligned access (sticky).

Function
REQ-014 FSM states SHALL be IDLE, REQ, DONE; encoding is free.
REQ-015 IDLE with core_ce_i=1 SHALL latch core_we_i, core_addr_i, core_wdata_i and move to REQ next cycle; IDLE with core_ce_i=0 SHALL stay in IDLE.
REQ-016 mem_stall_req_o SHALL be combinational: 1 when (IDLE and core_ce_i=1) or in REQ; 0 in DONE and in IDLE with core_ce_i=0.
REQ-017 bus_req_o SHALL be 1 exactly while in REQ.
REQ-018 bus_we_o, bus_addr_o and bus_wdata_o SHALL be driven from the latched values and SHALL stay stable while bus_req_o=1.
REQ-019 bus_addr_o SHALL be {latched_addr[31:2], 2'b00}.
REQ-020 A latched address with addr[1:0]!=0 SHALL set err_o and SHALL still be issued at the aligned address.
REQ-021 In REQ, bus_ack_i=1 SHALL move to DONE next cycle; for a read, bus_rdata_i SHALL be captured into core_rdata_o on that same edge.
REQ-022 A write SHALL leave core_rdata_o unchanged.
REQ-023 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-024 When the wait counter reaches TIMEOUT-1 without ack, the FSM SHALL move to DONE and set err_o; a read SHALL load core_rdata_o with 32'h0000_0000.
REQ-025 An ack and a timeout in the same cycle SHALL be treated as an ack: data captured, err_o not set by the timeout.
REQ-026 DONE SHALL last exactly one cycle, SHALL ignore core_ce_i (the still-held original request), and SHALL return to IDLE.
REQ-027 bus_ack_i outside REQ SHALL be ignored.
REQ-028 Latency: request first seen in cycle 0, ack in cycle k (k>=1) -> DONE in cycle k+1, so the stall is high for cycles 0..k; the minimum stall is 2 cycles.
REQ-029 Back-to-back requests SHALL each incur a full IDLE->REQ->DONE sequence; there is no overlap.

Reset
REQ-030 rst_n=1 at a clock edge SHALL force IDLE and clear core_rdata_o, the latched address/data/we, the wait counter and err_o to 0.
REQ-031 Outputs after reset SHALL be: bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, core_rdata_o=0, err_o=0; mem_stall_req_o follows core_ce_i.
REQ-032 Reset asserted during REQ SHALL drop bus_req_o in the following cycle; a late ack SHALL then be ignored.
REQ-033 err_o SHALL clear only on reset.

Verification
REQ-034 Read 0x0000_0010, ack after 3 REQ cycles with rdata 0xCAFE_0001 -> bus_addr_o=0x10, stall high 4 cycles, core_rdata_o=0xCAFE_0001 in DONE, err_o=0.
REQ-035 Write 0x0000_0024 data 0x1234_5678, ack in the first REQ cycle -> bus_we_o=1, bus_wdata_o=0x1234_5678, stall high 2 cycles, core_rdata_o unchanged.
REQ-036 Read with no ack, TIMEOUT=16 -> DONE after 16 REQ cycles, core_rdata_o=0, err_o=1 and held.
REQ-037 Read at 0x0000_0013 -> bus_addr_o=0x10, err_o=1.
REQ-038 Two consecutive loads with core_ce_i held high through DONE -> exactly two bus_req_o pulses, one IDLE cycle between DONE and the second REQ.
REQ-039 Reset in the 2nd REQ cycle, then ack -> bus_req_o=0 next cycle, state IDLE, core_rdata_o=0, ack ignored.

Source files
------------

// File: rtl/dmem_bridge.sv
// Bridges the core data port onto a request/acknowledge memory bus.
// One access at a time: IDLE -> REQ -> DONE. A read that gets no acknowledge in time returns zero and raises err_o.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_ce_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        mem_stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        accept_s;
  logic        timeout_s;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  assign accept_s  = (state_q == ST_IDLE) && core_ce_i;
  assign timeout_s = (state_q == ST_REQ) && !bus_ack_i && (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE deliberately ignores the still-held core request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core_ce_i) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack_i || timeout_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus_req_o       = 1'b0;
    mem_stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE: mem_stall_req_o = core_ce_i;
      ST_REQ: begin
        bus_req_o       = 1'b1;
        mem_stall_req_o = 1'b1;
      end
      ST_DONE: begin
        bus_req_o       = 1'b0;
        mem_stall_req_o = 1'b0;
      end
      default: begin
        bus_req_o       = 1'b0;
        mem_stall_req_o = 1'b0;
      end
    endcase
  end

  // Datapath next values: request latch, wait counter, read data, sticky error
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    err_d   = err_q;
    if (accept_s) begin
      we_d    = core_we_i;
      addr_d  = core_addr_i;
      wdata_d = core_wdata_i;
      wait_d  = 8'd0;
      if (misaligned(core_addr_i)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (state_q == ST_REQ) begin
      // An acknowledge in the last wait cycle wins over the timeout
      if (bus_ack_i) begin
        if (!we_q) begin
          rdata_d = bus_rdata_i;
        end else begin
          rdata_d = rdata_q;
        end
      end else if (timeout_s) begin
        err_d = 1'b1;
        if (!we_q) begin
          rdata_d = 32'h0000_0000;
        end else begin
          rdata_d = rdata_q;
        end
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else begin
      wait_d = wait_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign bus_we_o     = we_q;
  assign bus_addr_o   = {addr_q[31:2], 2'b00};
  assign bus_wdata_o  = wdata_q;
  assign core_rdata_o = rdata_q;
  assign err_o        = err_q;

  dmem_bridge_chk u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_req_o       (bus_req_o),
    .mem_stall_req_o (mem_stall_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_wdata_o     (bus_wdata_o)
  );

endmodule

// Protocol properties of the bridge outputs.
module dmem_bridge_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        bus_req_o,
  input logic        mem_stall_req_o,
  input logic        bus_we_o,
  input logic [31:0] bus_addr_o,
  input logic [31:0] bus_wdata_o
);

  a_req_stalls: assert property (@(posedge clk) disable iff (rst_n)
    bus_req_o |-> mem_stall_req_o);

  a_req_stable: assert property (@(posedge clk) disable iff (rst_n)
    (bus_req_o && $past(bus_req_o)) |->
      ($stable(bus_addr_o) && $stable(bus_wdata_o) && $stable(bus_we_o)));

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: read/write latency, timeout, misalignment, back-to-back and reset-in-flight.
module tb_dmem_bridge;

  logic        clk;
  logic        rst_n;
  logic        core_ce_i;
  logic        core_we_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        mem_stall_req_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  int vec_cnt;
  int err_cnt;

  int          stalls, reqs;
  logic [31:0] addr_seen, wdata_seen;
  logic        we_seen;
  logic        done_seen;

  dmem_bridge #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_ce_i       (core_ce_i),
    .core_we_i       (core_we_i),
    .core_addr_i     (core_addr_i),
    .core_wdata_i    (core_wdata_i),
    .core_rdata_o    (core_rdata_o),
    .mem_stall_req_o (mem_stall_req_o),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_ack_i       (bus_ack_i),
    .bus_rdata_i     (bus_rdata_i),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b1;
    core_ce_i = 1'b0;
    bus_ack_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
  endtask

  // Issue one access and hold it until the stall drops (DONE); ack in the ack_at-th REQ cycle, 0 = never
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata);
    core_ce_i    = 1'b1;
    core_we_i    = we;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    bus_ack_i    = 1'b0;
    stalls       = 0;
    reqs         = 0;
    done_seen    = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      if (!mem_stall_req_o) begin
        done_seen = 1'b1;
        break;
      end
      stalls++;
      if (bus_req_o) begin
        reqs++;
        addr_seen  = bus_addr_o;
        wdata_seen = bus_wdata_o;
        we_seen    = bus_we_o;
        if (reqs == ack_at) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = rdata;
        end
      end
      step();
      bus_ack_i = 1'b0;
    end
    chk("txn_done", {31'd0, done_seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt      = 0;
    err_cnt      = 0;
    rst_n        = 1'b1;
    core_ce_i    = 1'b0;
    core_we_i    = 1'b0;
    core_addr_i  = 32'h0;
    core_wdata_i = 32'h0;
    bus_ack_i    = 1'b0;
    bus_rdata_i  = 32'h0;
    @(negedge clk);
    step();
    step();
    #1;
    chk("rst_req",   {31'd0, bus_req_o}, 32'd0);
    chk("rst_we",    {31'd0, bus_we_o}, 32'd0);
    chk("rst_addr",  bus_addr_o, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall_req_o}, 32'd0);
    rst_n = 1'b0;
    step();

    // Read 0x10, ack in the third REQ cycle
    transact(1'b0, 32'h0000_0010, 32'h0, 3, 32'hCAFE_0001);
    chk("rd_stalls", stalls, 32'd4);
    chk("rd_reqs",   reqs, 32'd3);
    chk("rd_addr",   addr_seen, 32'h0000_0010);
    chk("rd_we",     {31'd0, we_seen}, 32'd0);
    chk("rd_done_req", {31'd0, bus_req_o}, 32'd0);
    chk("rd_rdata",  core_rdata_o, 32'hCAFE_0001);
    chk("rd_err",    {31'd0, err_o}, 32'd0);
    core_ce_i = 1'b0;
    step();

    // Write 0x24, ack in the first REQ cycle; rdata untouched
    transact(1'b1, 32'h0000_0024, 32'h1234_5678, 1, 32'hDEAD_BEEF);
    chk("wr_stalls", stalls, 32'd2);
    chk("wr_we",     {31'd0, we_seen}, 32'd1);
    chk("wr_wdata",  wdata_seen, 32'h1234_5678);
    chk("wr_addr",   addr_seen, 32'h0000_0024);
    chk("wr_rdata",  core_rdata_o, 32'hCAFE_0001);
    core_ce_i = 1'b0;
    step();

    // Read with no ack: 16 REQ cycles then DONE with zero data and sticky error
    transact(1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);
    chk("to_reqs",   reqs, 32'd16);
    chk("to_stalls", stalls, 32'd17);
    chk("to_rdata",  core_rdata_o, 32'h0);
    chk("to_err",    {31'd0, err_o}, 32'd1);
    core_ce_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    transact(1'b1, 32'h0000_0044, 32'h0000_0001, 1, 32'h0);
    core_ce_i = 1'b0;
    step();
    chk("to_err_held", {31'd0, err_o}, 32'd1);

    do_reset();
    chk("rst2_err",   {31'd0, err_o}, 32'd0);
    chk("rst2_rdata", core_rdata_o, 32'h0);
    step();

    // Ack arriving in the timeout cycle counts as an ack
    transact(1'b0, 32'h0000_0080, 32'h0, 16, 32'h5555_AAAA);
    chk("race_reqs",  reqs, 32'd16);
    chk("race_rdata", core_rdata_o, 32'h5555_AAAA);
    chk("race_err",   {31'd0, err_o}, 32'd0);
    core_ce_i = 1'b0;
    step();

    // Misaligned read is issued aligned and flags an error
    transact(1'b0, 32'h0000_0013, 32'h0, 2, 32'hA5A5_0013);
    chk("mis_addr",  addr_seen, 32'h0000_0010);
    chk("mis_err",   {31'd0, err_o}, 32'd1);
    chk("mis_rdata", core_rdata_o, 32'hA5A5_0013);
    core_ce_i = 1'b0;
    step();

    // Back-to-back loads with ce held through DONE
    transact(1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_0100);
    chk("b2b_req1", reqs, 32'd1);
    core_addr_i = 32'h0000_0104;
    step();
    #1;
    chk("b2b_gap_req",   {31'd0, bus_req_o}, 32'd0);
    chk("b2b_gap_stall", {31'd0, mem_stall_req_o}, 32'd1);
    transact(1'b0, 32'h0000_0104, 32'h0, 1, 32'h2222_0104);
    chk("b2b_req2",  reqs, 32'd1);
    chk("b2b_addr2", addr_seen, 32'h0000_0104);
    chk("b2b_rdata", core_rdata_o, 32'h2222_0104);
    core_ce_i = 1'b0;
    step();

    do_reset();
    step();

    // Reset during the second REQ cycle, then a late ack
    core_ce_i   = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h0000_0200;
    step();
    step();
    #1;
    chk("rr_in_req", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b1;
    step();
    #1;
    chk("rr_req_drop", {31'd0, bus_req_o}, 32'd0);
    chk("rr_addr",     bus_addr_o, 32'h0);
    rst_n       = 1'b0;
    core_ce_i   = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hBAD0_BAD0;
    step();
    #1;
    bus_ack_i = 1'b0;
    chk("rr_ack_req",   {31'd0, bus_req_o}, 32'd0);
    chk("rr_ack_rdata", core_rdata_o, 32'h0);
    chk("rr_ack_stall", {31'd0, mem_stall_req_o}, 32'd0);
    chk("rr_ack_err",   {31'd0, err_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
